// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter
//   Lets two pixel requesters share one combinational image ROM read port.
//   Arbitration is round-robin and the grant is combinational. The ROM
//   address and the returned pixel are both registered, so one read can be
//   accepted every cycle. Each read returns two edges after acceptance to
//   the requester that issued it, with a one-cycle valid pulse.
//
// Ports
//   Clock, Reset          : system clock, asynchronous active-high reset
//   req0/row0/col0        : requester 0 read request (level) and pixel address
//   gnt0                  : combinational grant to requester 0
//   valid0/pixel0         : requester 0 return pulse and returned pixel
//   req1 ... pixel1       : same set of signals for requester 1
//   rom_pix_row/col       : registered ROM address
//   rom_pixel             : ROM data for the current rom_pix_row/col
//   gnt_cnt0/gnt_cnt1/conflict_cnt : saturating statistics counters, present
//                           only when ROM_ARB_STATS_EN is defined
//
// Optional build macro: ROM_ARB_STATS_EN

module image_rom_arbiter #(
  parameter int unsigned IMG_ROWS  = 240,
  parameter int unsigned IMG_COLS  = 320,
  parameter logic [11:0] OOR_PIXEL = 12'h000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req0,
  input  logic [7:0]  row0,
  input  logic [8:0]  col0,
  output logic        gnt0,
  output logic        valid0,
  output logic [11:0] pixel0,
  input  logic        req1,
  input  logic [7:0]  row1,
  input  logic [8:0]  col1,
  output logic        gnt1,
  output logic        valid1,
  output logic [11:0] pixel1,
  output logic [7:0]  rom_pix_row,
  output logic [8:0]  rom_pix_col,
  input  logic [11:0] rom_pixel
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [15:0] gnt_cnt0,
  output logic [15:0] gnt_cnt1,
  output logic [15:0] conflict_cnt
`endif
);

  logic        last_grant_q, last_grant_d;
  logic        s1_valid_q,   s1_valid_d;
  logic        s1_tag_q,     s1_tag_d;
  logic        s1_oor_q,     s1_oor_d;
  logic [7:0]  rom_row_q,    rom_row_d;
  logic [8:0]  rom_col_q,    rom_col_d;
  logic        valid0_q,     valid0_d;
  logic        valid1_q,     valid1_d;
  logic [11:0] pixel0_q,     pixel0_d;
  logic [11:0] pixel1_q,     pixel1_d;

  logic        gnt0_c, gnt1_c;
  logic        accept, win_id, win_oor;
  logic [7:0]  win_row;
  logic [8:0]  win_col;
  logic [11:0] ret_pix;

  // On a tie the requester that did not win last time is granted;
  // last_grant resets to 1 so the first tie goes to requester 0.
  always_comb begin
    gnt0_c = req0 & (~req1 | last_grant_q);
    gnt1_c = req1 & (~req0 | ~last_grant_q);
  end

  assign gnt0 = gnt0_c;
  assign gnt1 = gnt1_c;

  always_comb begin
    accept  = gnt0_c | gnt1_c;
    win_id  = gnt1_c;
    win_row = win_id ? row1 : row0;
    win_col = win_id ? col1 : col0;
    win_oor = (32'(win_row) >= IMG_ROWS) || (32'(win_col) >= IMG_COLS);
    ret_pix = s1_oor_q ? OOR_PIXEL : rom_pixel;

    last_grant_d = last_grant_q;
    rom_row_d    = rom_row_q;
    rom_col_d    = rom_col_q;
    s1_tag_d     = s1_tag_q;
    s1_oor_d     = s1_oor_q;
    s1_valid_d   = accept;
    if (accept) begin
      // Out-of-range reads still occupy the pipeline but park the ROM at 0/0.
      rom_row_d    = win_oor ? '0 : win_row;
      rom_col_d    = win_oor ? '0 : win_col;
      s1_tag_d     = win_id;
      s1_oor_d     = win_oor;
      last_grant_d = win_id;
    end

    valid0_d = s1_valid_q & ~s1_tag_q;
    valid1_d = s1_valid_q &  s1_tag_q;
    pixel0_d = valid0_d ? ret_pix : pixel0_q;
    pixel1_d = valid1_d ? ret_pix : pixel1_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last_grant_q <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= 1'b0;
      s1_oor_q     <= 1'b0;
      rom_row_q    <= '0;
      rom_col_q    <= '0;
      valid0_q     <= 1'b0;
      valid1_q     <= 1'b0;
      pixel0_q     <= '0;
      pixel1_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      s1_oor_q     <= s1_oor_d;
      rom_row_q    <= rom_row_d;
      rom_col_q    <= rom_col_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
      pixel0_q     <= pixel0_d;
      pixel1_q     <= pixel1_d;
    end
  end

  assign rom_pix_row = rom_row_q;
  assign rom_pix_col = rom_col_q;
  assign valid0      = valid0_q;
  assign valid1      = valid1_q;
  assign pixel0      = pixel0_q;
  assign pixel1      = pixel1_q;

`ifdef ROM_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0] gnt_cnt1_q, gnt_cnt1_d;
  logic [15:0] conf_cnt_q, conf_cnt_d;

  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    conf_cnt_d = conf_cnt_q;
    if (gnt0_c && gnt_cnt0_q != '1) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (gnt1_c && gnt_cnt1_q != '1) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
    if (req0 && req1 && conf_cnt_q != '1) conf_cnt_d = conf_cnt_q + 16'd1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign gnt_cnt0     = gnt_cnt0_q;
  assign gnt_cnt1     = gnt_cnt1_q;
  assign conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Testbench for image_rom_arbiter: directed scenarios followed by randomized
// traffic, compared against a transaction-level model of the arbiter.
// Honours ROM_ARB_STATS_EN when defined.

module tb_image_rom_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        req0, req1;
  logic [7:0]  row0, row1;
  logic [8:0]  col0, col1;
  logic        gnt0, gnt1, valid0, valid1;
  logic [11:0] pixel0, pixel1;
  logic [7:0]  rom_pix_row;
  logic [8:0]  rom_pix_col;
  logic [11:0] rom_pixel;
`ifdef ROM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  always #5 Clock = ~Clock;

  image_rom_arbiter #(
    .IMG_ROWS (240),
    .IMG_COLS (320),
    .OOR_PIXEL(12'h000)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .req0       (req0),
    .row0       (row0),
    .col0       (col0),
    .gnt0       (gnt0),
    .valid0     (valid0),
    .pixel0     (pixel0),
    .req1       (req1),
    .row1       (row1),
    .col1       (col1),
    .gnt1       (gnt1),
    .valid1     (valid1),
    .pixel1     (pixel1),
    .rom_pix_row(rom_pix_row),
    .rom_pix_col(rom_pix_col),
    .rom_pixel  (rom_pixel)
`ifdef ROM_ARB_STATS_EN
    ,
    .gnt_cnt0    (gnt_cnt0),
    .gnt_cnt1    (gnt_cnt1),
    .conflict_cnt(conflict_cnt)
`endif
  );

  // Image ROM contents: a fixed pattern, with 12'hABC planted at (10,20).
  function automatic logic [11:0] rom_fn(input logic [7:0] r, input logic [8:0] c);
    int v;
    if (r == 8'd10 && c == 9'd20) return 12'hABC;
    v = (int'(r) * 37 + int'(c) * 11 + 53) % 4096;
    return 12'(v) ^ 12'h5A5;
  endfunction

  assign rom_pixel = rom_fn(rom_pix_row, rom_pix_col);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: each accepted read becomes a pending return
  // due one model edge after the accepting edge.
  typedef struct {
    int          tag;
    logic [11:0] pix;
    int          due;
  } ret_t;

  ret_t        pend[$];
  int          cyc;
  int          m_last;
  logic        m_v0, m_v1, m_g0, m_g1;
  logic [11:0] m_p0, m_p1;
  logic [7:0]  m_row;
  logic [8:0]  m_col;
  int          m_cnt0, m_cnt1, m_conf;

  task automatic model_reset();
    pend.delete();
    m_last = 1;
    m_v0 = 0; m_v1 = 0; m_p0 = '0; m_p1 = '0;
    m_row = '0; m_col = '0;
    m_cnt0 = 0; m_cnt1 = 0; m_conf = 0;
  endtask

  task automatic check_outputs();
    check("valid0", 32'(valid0), 32'(m_v0));
    check("valid1", 32'(valid1), 32'(m_v1));
    check("pixel0", 32'(pixel0), 32'(m_p0));
    check("pixel1", 32'(pixel1), 32'(m_p1));
    check("rom_row", 32'(rom_pix_row), 32'(m_row));
    check("rom_col", 32'(rom_pix_col), 32'(m_col));
`ifdef ROM_ARB_STATS_EN
    check("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt0));
    check("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt1));
    check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`endif
  endtask

  // One clock cycle: check registered outputs, drive inputs, check the
  // grant, then advance the model across the rising edge.
  task automatic cycle(input logic r0, input logic [7:0] rw0, input logic [8:0] cl0,
                       input logic r1, input logic [7:0] rw1, input logic [8:0] cl1);
    int   w;
    logic oor;
    logic [7:0] ar;
    logic [8:0] ac;
    ret_t r;
    @(negedge Clock);
    check_outputs();
    req0 = r0; row0 = rw0; col0 = cl0;
    req1 = r1; row1 = rw1; col1 = cl1;
    #1;
    if (r0 && r1) w = (m_last == 0) ? 1 : 0;
    else if (r0)  w = 0;
    else if (r1)  w = 1;
    else          w = -1;
    m_g0 = (w == 0);
    m_g1 = (w == 1);
    check("gnt0", 32'(gnt0), 32'(m_g0));
    check("gnt1", 32'(gnt1), 32'(m_g1));
    @(posedge Clock);
    cyc++;
    m_v0 = 0; m_v1 = 0;
    while (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (r.tag == 0) begin m_v0 = 1; m_p0 = r.pix; end
      else            begin m_v1 = 1; m_p1 = r.pix; end
    end
    if (w >= 0) begin
      ar  = (w == 0) ? rw0 : rw1;
      ac  = (w == 0) ? cl0 : cl1;
      oor = (ar >= 8'd240) || (ac >= 9'd320);
      pend.push_back('{w, oor ? 12'h000 : rom_fn(ar, ac), cyc + 1});
      m_row  = oor ? 8'd0 : ar;
      m_col  = oor ? 9'd0 : ac;
      m_last = w;
      if (w == 0 && m_cnt0 < 65535) m_cnt0++;
      if (w == 1 && m_cnt1 < 65535) m_cnt1++;
    end
    if (r0 && r1 && m_conf < 65535) m_conf++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'd0, 9'd0, 0, 8'd0, 9'd0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    req0 = 0; req1 = 0;
    #1;
    model_reset();
    check("rst_valid0", 32'(valid0), 32'd0);
    check("rst_valid1", 32'(valid1), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  function automatic logic [7:0] rand_row();
    case ($urandom % 8)
      0:       return 8'd239;
      1:       return 8'd240;
      2:       return 8'd255;
      default: return 8'($urandom_range(0, 239));
    endcase
  endfunction

  function automatic logic [8:0] rand_col();
    case ($urandom % 8)
      0:       return 9'd319;
      1:       return 9'd320;
      2:       return 9'd511;
      default: return 9'($urandom_range(0, 319));
    endcase
  endfunction

  initial begin
    logic       r0, r1;
    logic [7:0] rw0, rw1;
    logic [8:0] cl0, cl1;
    cyc = 0;
    req0 = 0; req1 = 0; row0 = '0; row1 = '0; col0 = '0; col1 = '0;
    Reset = 1'b1;
    model_reset();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    // Idle after reset: everything stays at zero.
    idle(5);

    // Single read from requester 0 at (10,20).
    cycle(1, 8'd10, 9'd20, 0, 8'd0, 9'd0);
    idle(3);
    check("pix_abc", 32'(pixel0), 32'h0ABC);

    // Sustained contention, distinct addresses per requester.
    for (int i = 0; i < 6; i++) cycle(1, 8'd3, 9'd4, 1, 8'd100, 9'd200);
    idle(3);

    // Out-of-range requests from requester 1 (row, then column).
    cycle(0, 8'd0, 9'd0, 1, 8'd240, 9'd5);
    idle(3);
    cycle(0, 8'd0, 9'd0, 1, 8'd5, 9'd320);
    idle(3);

    // Back-to-back reads from requester 0.
    for (int i = 0; i < 4; i++) cycle(1, 8'd0, 9'(i), 0, 8'd0, 9'd0);
    idle(3);

    // Reset between acceptance and return drops the read; then first tie -> 0.
    cycle(1, 8'd10, 9'd20, 0, 8'd0, 9'd0);
    do_reset();
    cycle(1, 8'd7, 9'd8, 1, 8'd9, 9'd10);
    check("tie_after_rst", 32'(m_g0), 32'd1);
    idle(3);

    // Randomized traffic; a waiting requester holds its request and address.
    r0 = 0; r1 = 0; rw0 = '0; rw1 = '0; cl0 = '0; cl1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(r0 && !m_g0)) begin
        r0 = ($urandom % 4) != 0; rw0 = rand_row(); cl0 = rand_col();
      end
      if (!(r1 && !m_g1)) begin
        r1 = ($urandom % 4) != 0; rw1 = rand_row(); cl1 = rand_col();
      end
      cycle(r0, rw0, cl0, r1, rw1, cl1);
      if (i == 200) begin
        do_reset();
        r0 = 0; r1 = 0; m_g0 = 0; m_g1 = 0;
      end
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
